// File: rtl/packet_buffer_pkg.sv
// Shared types and helpers for the variable-length packet ring buffer.
package packet_buffer_pkg;

    localparam int width_narrow_lp = 32;
    localparam int width_mid_lp    = 64;
    localparam int width_wide_lp   = 128;

    // Fields are sized for the largest supported configuration; narrower builds leave upper bits zero.
    typedef struct packed {
        logic [15:0] base;
        logic [15:0] size;
    } desc_s;

    function automatic int bytes_to_words(int size, int bpw);
        return (size + bpw - 1) / bpw;
    endfunction

    function automatic bit width_is_legal(int w);
        return (w == width_narrow_lp) || (w == width_mid_lp) || (w == width_wide_lp);
    endfunction

endpackage

// File: rtl/packet_ring_desc_queue.sv
// Descriptor FIFO for committed packets; head entry is presented combinationally.
module packet_ring_desc_queue
    import packet_buffer_pkg::*;
#(
    parameter int depth_p = 8
) (
    input  logic  clk_i,
    input  logic  reset_i,
    input  logic  push_i,
    input  desc_s push_desc_i,
    input  logic  pop_i,
    output desc_s head_o,
    output logic  full_o,
    output logic  empty_o
);

    localparam int ptr_width_lp = $clog2(depth_p);

    desc_s                   slots [depth_p];
    logic [ptr_width_lp-1:0] wr_ptr_q;
    logic [ptr_width_lp-1:0] rd_ptr_q;
    logic [ptr_width_lp:0]   count_q;
    logic                    do_push;
    logic                    do_pop;

    assign full_o  = (count_q == (ptr_width_lp + 1)'(depth_p));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = slots[rd_ptr_q];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < depth_p; i++) begin
                slots[i] <= '0;
            end
        end else begin
            if (do_push) begin
                slots[wr_ptr_q] <= push_desc_i;
                wr_ptr_q        <= wr_ptr_q + ptr_width_lp'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + ptr_width_lp'(1);
            end
            count_q <= count_q + (ptr_width_lp + 1)'(do_push) - (ptr_width_lp + 1)'(do_pop);
        end
    end

endmodule

// File: rtl/packet_ring_buffer.sv
// Packet buffer storing variable-length packets back-to-back in one circular word memory,
// with a descriptor queue of committed packets, abort/drop accounting and free-space reporting.
module packet_ring_buffer
    import packet_buffer_pkg::*;
#(
    parameter int data_width_p     = 64,
    parameter int els_p            = 8192,
    parameter int max_packet_els_p = 2048,
    parameter int desc_els_p       = 8,
    localparam int bpw_lp          = data_width_p / 8,
    localparam int words_lp        = els_p / bpw_lp,
    localparam int size_width_lp   = $clog2(max_packet_els_p + 1),
    localparam int off_width_lp    = $clog2(max_packet_els_p),
    localparam int free_width_lp   = $clog2(els_p + 1)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    output logic                     packet_avail_o,
    input  logic                     packet_ack_i,
    input  logic                     packet_rvalid_i,
    input  logic [off_width_lp-1:0]  packet_raddr_i,
    output logic [data_width_p-1:0]  packet_rdata_o,
    output logic [size_width_lp-1:0] packet_rsize_o,
    output logic                     packet_req_o,
    input  logic                     packet_send_i,
    input  logic                     packet_abort_i,
    input  logic                     packet_wsize_valid_i,
    input  logic [size_width_lp-1:0] packet_wsize_i,
    input  logic                     packet_wvalid_i,
    input  logic [off_width_lp-1:0]  packet_waddr_i,
    input  logic [data_width_p-1:0]  packet_wdata_i,
    input  logic [bpw_lp-1:0]        packet_wmask_i,
    output logic [free_width_lp-1:0] free_bytes_o,
    output logic [15:0]              drop_count_o
);

    localparam int shift_lp       = $clog2(bpw_lp);
    localparam int waddr_width_lp = $clog2(words_lp);
    localparam int used_width_lp  = $clog2(words_lp + 1);
    localparam int max_words_lp   = bytes_to_words(max_packet_els_p, bpw_lp);

    logic [data_width_p-1:0]   mem [words_lp];
    logic [data_width_p-1:0]   rdata_q;
    logic [waddr_width_lp-1:0] wr_base_q;
    logic [used_width_lp-1:0]  used_q;
    logic [size_width_lp-1:0]  open_size_q;
    logic [15:0]               drop_q;

    logic [used_width_lp-1:0]  free_words;
    logic [used_width_lp-1:0]  commit_words;
    logic [used_width_lp-1:0]  ack_words;
    logic [waddr_width_lp-1:0] wr_word;
    logic [waddr_width_lp-1:0] rd_word;
    logic                      size_ok;
    logic                      do_commit;
    logic                      do_drop;
    logic                      do_ack;
    logic                      do_read;
    logic                      do_write;

    desc_s head;
    desc_s push_desc;
    logic  desc_full;
    logic  desc_empty;
    logic  unused_head;

    // Space accounting uses a word counter so a completely full ring is distinguishable from empty.
    assign free_words   = used_width_lp'(words_lp) - used_q;
    assign packet_req_o = (free_words >= used_width_lp'(max_words_lp)) && !desc_full;

    assign size_ok      = (open_size_q != '0) && (open_size_q <= size_width_lp'(max_packet_els_p));
    assign do_drop      = packet_req_o && (packet_abort_i || (packet_send_i && !size_ok));
    assign do_commit    = packet_req_o && packet_send_i && !packet_abort_i && size_ok;
    assign do_ack       = packet_ack_i && !desc_empty;
    assign do_read      = packet_rvalid_i && !desc_empty;
    assign do_write     = packet_wvalid_i && packet_req_o;

    assign commit_words = used_width_lp'(bytes_to_words(int'(open_size_q), bpw_lp));
    assign ack_words    = used_width_lp'(bytes_to_words(int'(head.size), bpw_lp));

    assign wr_word = wr_base_q + waddr_width_lp'(packet_waddr_i >> shift_lp);
    assign rd_word = head.base[waddr_width_lp-1:0] + waddr_width_lp'(packet_raddr_i >> shift_lp);

    assign push_desc.base = 16'(wr_base_q);
    assign push_desc.size = 16'(open_size_q);

    packet_ring_desc_queue #(
        .depth_p (desc_els_p)
    ) desc_queue (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .push_i      (do_commit),
        .push_desc_i (push_desc),
        .pop_i       (do_ack),
        .head_o      (head),
        .full_o      (desc_full),
        .empty_o     (desc_empty)
    );

    assign unused_head = ^{head.base[15:waddr_width_lp], head.size[15:size_width_lp]};

    always_ff @(posedge clk_i) begin
        if (do_write) begin
            for (int b = 0; b < bpw_lp; b++) begin
                if (packet_wmask_i[b]) begin
                    mem[wr_word][8*b +: 8] <= packet_wdata_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rdata_q <= '0;
        end else if (do_read) begin
            rdata_q <= mem[rd_word];
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_base_q   <= '0;
            used_q      <= '0;
            open_size_q <= '0;
            drop_q      <= '0;
        end else begin
            if (do_commit) begin
                wr_base_q <= wr_base_q + waddr_width_lp'(commit_words);
            end
            used_q <= used_q + (do_commit ? commit_words : '0) - (do_ack ? ack_words : '0);
            if (do_drop) begin
                open_size_q <= '0;
            end else if (packet_wsize_valid_i && packet_req_o) begin
                open_size_q <= packet_wsize_i;
            end
            if (do_drop && (drop_q != 16'hFFFF)) begin
                drop_q <= drop_q + 16'd1;
            end
        end
    end

    assign packet_avail_o = !desc_empty;
    assign packet_rsize_o = desc_empty ? '0 : head.size[size_width_lp-1:0];
    assign packet_rdata_o = rdata_q;
    assign free_bytes_o   = free_width_lp'(free_words) << shift_lp;
    assign drop_count_o   = drop_q;

`ifndef SYNTHESIS
    function automatic bit mask_aligned(logic [bpw_lp-1:0] m);
        int                n;
        int                lo;
        logic [bpw_lp-1:0] ref_m;
        n  = $countones(m);
        lo = 0;
        if (n == 0) return 1'b1;
        for (int b = bpw_lp - 1; b >= 0; b--) begin
            if (m[b]) lo = b;
        end
        ref_m = bpw_lp'(((64'd1 << n) - 64'd1) << lo);
        return ((n & (n - 1)) == 0) && ((lo % n) == 0) && (m == ref_m);
    endfunction

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (width_is_legal(data_width_p))
                else $error("unsupported data_width_p %0d", data_width_p);
            if (packet_wvalid_i) begin
                assert (mask_aligned(packet_wmask_i))
                    else $error("write mask %0h not naturally aligned", packet_wmask_i);
                assert (size_width_lp'(packet_waddr_i) < size_width_lp'(max_packet_els_p))
                    else $error("write offset %0d beyond largest packet", packet_waddr_i);
            end
            if (packet_rvalid_i) begin
                assert (packet_raddr_i[shift_lp-1:0] == '0)
                    else $error("read offset %0d not word aligned", packet_raddr_i);
            end
        end
    end
`endif

endmodule
